calc_cmd_seq: RTL and testbench

Command sequencer that drives the calculator core's `cmd`/`status` interface from the initiator side. Key codes pushed by a keypad or host are buffered in a small FIFO and issued one at a time: present the code on `cmd`, hold it, wait for the core to acknowledge by leaving the ready status, release to the idle code, then wait for ready again. The block sits between the input front-end and `calc_top`, replacing hand-timed stimulus with a protocol-correct driver.

---
 rtl/calc_cmd_seq.sv | 174 +++++++++++++++++
 tb/tb_calc_cmd_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_seq.sv
// calc_cmd_seq: buffers keypad codes in a FIFO and issues them to the calc
// core over cmd/status (present, hold, wait for ack, release, wait for ready).
// Ports: clock, reset (async, active-low); key_valid/key_code/key_ready push
// side; status (core) in, cmd out; busy, fifo_count; sticky err_timeout and
// err_calc, both cleared by err_clr.
module calc_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             key_code,
    output logic                   key_ready,
    input  logic                   err_clr,
    input  logic [1:0]             status,
    output logic [3:0]             cmd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_timeout,
    output logic                   err_calc
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [3:0] NOP     = 4'b1111;
    localparam logic [1:0] S_READY = 2'b01;
    localparam logic [1:0] S_FAULT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        ACK,
        RELEASE,
        ERROR
    } state_t;

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          core_err;
    logic          ready;
    logic          push;
    logic          pop;
    logic          hold_done;
    logic          wait_done;

    assign core_err = (status == S_FAULT);
    assign ready    = (status == S_READY);

    // Both are decodes of registered state only, so they move on clock edges.
    assign key_ready = (state != ERROR)
                     && (fifo_count < (AW+1)'(DEPTH));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    // Reserved code is silently dropped; a core fault flushes instead.
    assign push = key_valid && key_ready
               && (key_code != NOP) && !core_err;
    assign pop  = (state == IDLE) && (fifo_count != '0) && ready;

    // Saturating so a long wait can never wrap back into range.
    assign timer_inc = (&timer) ? timer : timer + TW'(1);
    assign hold_done = (timer == TW'(HOLD - 1));
    assign wait_done = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (core_err) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count
                        + (AW+1)'(push)
                        - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd         <= NOP;
            timer       <= '0;
            err_timeout <= 1'b0;
            err_calc    <= 1'b0;
        end else begin
            // Any set below is a later assignment, so it beats the clear.
            if (err_clr) begin
                err_timeout <= 1'b0;
                err_calc    <= 1'b0;
            end
            if (core_err) begin
                err_calc <= 1'b1;
                state    <= ERROR;
                cmd      <= NOP;
                timer    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pop) begin
                            cmd   <= mem[rd_ptr];
                            state <= DRIVE;
                            timer <= '0;
                        end
                    end
                    DRIVE: begin
                        if (hold_done) begin
                            state <= ACK;
                            timer <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    ACK: begin
                        if (!ready || wait_done) begin
                            if (ready) begin
                                err_timeout <= 1'b1;
                            end
                            state <= RELEASE;
                            cmd   <= NOP;
                            timer <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    RELEASE: begin
                        if (ready || wait_done) begin
                            if (!ready) begin
                                err_timeout <= 1'b1;
                            end
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    ERROR: begin
                        if (ready) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cmd   <= NOP;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_seq.sv
// tb_calc_cmd_seq: directed scenarios for calc_cmd_seq with a small
// behavioural core model answering the cmd/status handshake.
module tb_calc_cmd_seq;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int DEPTH   = 8;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       err_clr;
    logic [1:0] status;
    logic [3:0] cmd;
    logic       busy;
    logic [3:0] fifo_count;
    logic       err_timeout;
    logic       err_calc;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] got [$];
    int         viol;
    bit         tmo;

    always #5 clock = ~clock;

    calc_cmd_seq #(
        .DEPTH(DEPTH),
        .HOLD(HOLD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ready(key_ready),
        .err_clr(err_clr),
        .status(status),
        .cmd(cmd),
        .busy(busy),
        .fifo_count(fifo_count),
        .err_timeout(err_timeout),
        .err_calc(err_calc)
    );

    // Core model: drop to busy the cycle after a new code shows up,
    // back to ready three cycles later. Records issued codes and counts
    // protocol violations (short hold, code-to-code without idle).
    task automatic run_core(input int n_exp, input int max_cyc);
        logic [3:0] prev;
        int run;
        int cnt;
        got.delete();
        viol = 0;
        tmo = 1'b1;
        status = 2'b01;
        prev = cmd;
        run = 0;
        cnt = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) status = 2'b01;
            end
            if (cmd != 4'hf && prev == 4'hf) begin
                got.push_back(cmd);
                status = 2'b10;
                cnt = 3;
                run = 1;
            end else if (cmd != 4'hf && cmd == prev) begin
                run++;
            end else if (cmd != 4'hf) begin
                viol++;
            end else if (prev != 4'hf && run < HOLD) begin
                viol++;
            end
            prev = cmd;
            if (got.size() == n_exp && !busy && cmd == 4'hf) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        err_clr = 1'b0;
        status = 2'b00;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({cmd, key_ready, busy, fifo_count, err_timeout, err_calc}
            !== {4'hf, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_hold: got %h,%b,%b,%0d,%b,%b want f,1,0,0,0,0",
                     cmd, key_ready, busy, fifo_count, err_timeout, err_calc);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({cmd, key_ready, busy, fifo_count, err_timeout, err_calc}
            !== {4'hf, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_release: got %h,%b,%b,%0d,%b,%b want f,1,0,0,0,0",
                     cmd, key_ready, busy, fifo_count, err_timeout, err_calc);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] want [5];
        want = '{4'h1, 4'h2, 4'ha, 4'h3, 4'he};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    key_valid = 1'b1;
                    key_code = want[i];
                    @(negedge clock);
                end
                key_valid = 1'b0;
            end
            run_core(5, 200);
        join
        n_cmp++;
        if (tmo || got.size() != 5) begin
            n_fail++;
            $display("FAIL seq_done: timeout %b count %0d want 0 5", tmo, got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL seq_code%0d: got %h want %h", i, got[i], want[i]);
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL seq_proto: got %0d violations want 0", viol);
        end
        n_cmp++;
        if ({fifo_count, busy, err_timeout, err_calc, cmd}
            !== {4'd0, 1'b0, 1'b0, 1'b0, 4'hf}) begin
            n_fail++;
            $display("FAIL seq_end: got %0d,%b,%b,%b,%h want 0,0,0,0,f",
                     fifo_count, busy, err_timeout, err_calc, cmd);
        end
    endtask

    task automatic test_full();
        status = 2'b00;
        for (int i = 0; i < 9; i++) begin
            key_valid = 1'b1;
            key_code = 4'(i + 1);
            @(negedge clock);
            if (i == 7) begin
                n_cmp++;
                if (key_ready !== 1'b0 || fifo_count !== 4'd8) begin
                    n_fail++;
                    $display("FAIL full_at8: got ready %b count %0d want 0 8",
                             key_ready, fifo_count);
                end
            end
        end
        key_valid = 1'b0;
        n_cmp++;
        if ({fifo_count, key_ready, cmd} !== {4'd8, 1'b0, 4'hf}) begin
            n_fail++;
            $display("FAIL full_ninth: got %0d,%b,%h want 8,0,f",
                     fifo_count, key_ready, cmd);
        end
        run_core(8, 300);
        n_cmp++;
        if (tmo || got.size() != 8 || viol != 0) begin
            n_fail++;
            $display("FAIL full_drain: timeout %b count %0d viol %0d want 0 8 0",
                     tmo, got.size(), viol);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL full_code%0d: got %h want %h", i, got[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        status = 2'b01;
        key_valid = 1'b1;
        key_code = 4'h5;
        @(negedge clock);
        key_code = 4'h6;
        @(negedge clock);
        key_valid = 1'b0;
        k = 0;
        while (cmd !== 4'h5 && k < 10) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (cmd !== 4'h5) begin
            n_fail++;
            $display("FAIL to_issue: got %h want 5", cmd);
        end
        k = 0;
        while (err_timeout !== 1'b1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (k != HOLD + TIMEOUT) begin
            n_fail++;
            $display("FAIL to_cycles: got %0d want %0d", k, HOLD + TIMEOUT);
        end
        n_cmp++;
        if (cmd !== 4'hf) begin
            n_fail++;
            $display("FAIL to_release: got %h want f", cmd);
        end
        k = 0;
        while (cmd !== 4'h6 && k < 10) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (cmd !== 4'h6) begin
            n_fail++;
            $display("FAIL to_next: got %h want 6", cmd);
        end
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clr: got %b want 0", err_timeout);
        end
        status = 2'b10;
        repeat (3) @(negedge clock);
        status = 2'b01;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if ({busy, err_timeout, cmd} !== {1'b0, 1'b0, 4'hf}) begin
            n_fail++;
            $display("FAIL to_drain: got %b,%b,%h want 0,0,f",
                     busy, err_timeout, cmd);
        end
    endtask

    task automatic test_calc_err();
        int k;
        status = 2'b00;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_code = 4'(i + 1);
            @(negedge clock);
        end
        key_valid = 1'b0;
        status = 2'b01;
        k = 0;
        while (cmd === 4'hf && k < 10) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (cmd !== 4'h1 || fifo_count !== 4'd3) begin
            n_fail++;
            $display("FAIL ce_drive: got %h,%0d want 1,3", cmd, fifo_count);
        end
        status = 2'b11;
        @(negedge clock);
        n_cmp++;
        if ({err_calc, cmd, fifo_count, key_ready, busy}
            !== {1'b1, 4'hf, 4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ce_enter: got %b,%h,%0d,%b,%b want 1,f,0,0,1",
                     err_calc, cmd, fifo_count, key_ready, busy);
        end
        key_valid = 1'b1;
        key_code = 4'h7;
        @(negedge clock);
        key_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ce_nopush: got %0d want 0", fifo_count);
        end
        status = 2'b01;
        @(negedge clock);
        n_cmp++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_exit: got ready %b busy %b want 1 0", key_ready, busy);
        end
        key_valid = 1'b1;
        key_code = 4'h3;
        @(negedge clock);
        key_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL ce_push: got %0d want 1", fifo_count);
        end
        run_core(1, 50);
        n_cmp++;
        if (tmo || got.size() != 1 || got[0] !== 4'h3) begin
            n_fail++;
            $display("FAIL ce_issue: timeout %b count %0d want 0 1 (code 3)",
                     tmo, got.size());
        end
        n_cmp++;
        if (err_calc !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_sticky: got %b want 1", err_calc);
        end
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        n_cmp++;
        if (err_calc !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_clr: got %b want 0", err_calc);
        end
    endtask

    task automatic test_drop_full();
        status = 2'b00;
        key_valid = 1'b1;
        key_code = 4'hf;
        @(negedge clock);
        key_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_nop: got count %0d busy %b want 0 0", fifo_count, busy);
        end
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_code = 4'(i + 1);
            @(negedge clock);
        end
        key_code = 4'h9;
        status = 2'b01;
        @(negedge clock);
        key_valid = 1'b0;
        n_cmp++;
        if ({fifo_count, cmd, key_ready} !== {4'd7, 4'h1, 1'b1}) begin
            n_fail++;
            $display("FAIL full_pop: got %0d,%h,%b want 7,1,1",
                     fifo_count, cmd, key_ready);
        end
        status = 2'b10;
        repeat (3) @(negedge clock);
        run_core(7, 300);
        n_cmp++;
        if (tmo || got.size() != 7 || got[0] !== 4'h2 || got[6] !== 4'h8) begin
            n_fail++;
            $display("FAIL full_rest: timeout %b count %0d want 0 7 (2..8)",
                     tmo, got.size());
        end
    endtask

    task automatic test_async_reset();
        int k;
        status = 2'b00;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_code = 4'(i + 4);
            @(negedge clock);
        end
        key_valid = 1'b0;
        status = 2'b01;
        k = 0;
        while (cmd === 4'hf && k < 10) begin
            @(negedge clock);
            k++;
        end
        repeat (HOLD) @(negedge clock);
        n_cmp++;
        if (cmd !== 4'h4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_ack: got %h,%b want 4,1", cmd, busy);
        end
        #2;
        reset = 1'b0;
        #0.5;
        n_cmp++;
        if ({cmd, key_ready, busy, fifo_count, err_timeout, err_calc}
            !== {4'hf, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ar_async: got %h,%b,%b,%0d,%b,%b want f,1,0,0,0,0",
                     cmd, key_ready, busy, fifo_count, err_timeout, err_calc);
        end
        #0.5;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++;
        if ({cmd, busy, fifo_count} !== {4'hf, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL ar_lost: got %h,%b,%0d want f,0,0", cmd, busy, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full();
        test_timeout();
        test_calc_err();
        test_drop_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
